// File: rtl/rom_arbiter.sv
// Shares the single instruction-ROM read port between fetch (IF) and loads (LD).
// The winner is chosen combinationally; its word and fault status come back one cycle later.
module rom_arbiter #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] ROM_BASE      = 32'hBFC00000,
    parameter logic [ADDRESS_WIDTH-1:0] ROM_SIZE      = 32'h1000,
    parameter int                       STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    input  logic                     if_flush,
    output logic                     if_gnt,
    output logic                     if_rvalid,
    output logic [ADDRESS_WIDTH-1:0] if_rdata,
    output logic                     if_err,
    input  logic                     ld_req,
    input  logic [ADDRESS_WIDTH-1:0] ld_addr,
    output logic                     ld_gnt,
    output logic                     ld_rvalid,
    output logic [ADDRESS_WIDTH-1:0] ld_rdata,
    output logic                     ld_err,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [ADDRESS_WIDTH-1:0] rom_dout
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    // One extra bit so that addr+3 near the top of the address space cannot wrap.
    localparam logic [ADDRESS_WIDTH:0] RANGE_LO = {1'b0, ROM_BASE};
    localparam logic [ADDRESS_WIDTH:0] RANGE_HI = {1'b0, ROM_BASE} + {1'b0, ROM_SIZE} - 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RESP_IF,
        RESP_LD
    } resp_state_t;

    resp_state_t              resp_state_reg;
    logic [CNT_W-1:0]         starve_cnt_reg;
    logic [ADDRESS_WIDTH-1:0] rom_addr_reg;
    logic [ADDRESS_WIDTH-1:0] if_rdata_reg;
    logic [ADDRESS_WIDTH-1:0] ld_rdata_reg;
    logic                     err_reg;

    logic                     starve_hit;
    logic                     if_win;
    logic                     ld_win;
    logic [ADDRESS_WIDTH-1:0] gnt_addr;
    logic [ADDRESS_WIDTH:0]   addr_ext;
    logic                     fault;
    logic [ADDRESS_WIDTH-1:0] word_next;

    always_comb begin
        starve_hit = (starve_cnt_reg == STARVE_MAX);
        if_win     = rst && if_req && (!ld_req || starve_hit);
        ld_win     = rst && ld_req && !if_win;
        gnt_addr   = if_win ? if_addr : ld_addr;
        addr_ext   = {1'b0, gnt_addr};
        fault      = (addr_ext < RANGE_LO)
                  || ((addr_ext + (ADDRESS_WIDTH+1)'(3)) > RANGE_HI)
                  || (if_win && (gnt_addr[1:0] != 2'b00));
        word_next  = fault ? '0 : rom_dout;
    end

    assign if_gnt    = if_win;
    assign ld_gnt    = ld_win;
    assign rom_addr  = (if_win || ld_win) ? gnt_addr : rom_addr_reg;
    // A flush in the response cycle drops the fetch word, fault included.
    assign if_rvalid = rst && (resp_state_reg == RESP_IF) && !if_flush;
    assign if_err    = if_rvalid && err_reg;
    assign ld_rvalid = rst && (resp_state_reg == RESP_LD);
    assign ld_err    = ld_rvalid && err_reg;
    assign if_rdata  = if_rdata_reg;
    assign ld_rdata  = ld_rdata_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_state_reg <= IDLE;
            starve_cnt_reg <= '0;
            rom_addr_reg   <= ROM_BASE;
            if_rdata_reg   <= '0;
            ld_rdata_reg   <= '0;
            err_reg        <= 1'b0;
        end else begin
            if (if_win) begin
                resp_state_reg <= RESP_IF;
            end else if (ld_win) begin
                resp_state_reg <= RESP_LD;
            end else begin
                resp_state_reg <= IDLE;
            end

            if (if_win || ld_win) begin
                rom_addr_reg <= gnt_addr;
                err_reg      <= fault;
            end
            if (if_win) begin
                if_rdata_reg <= word_next;
            end
            if (ld_win) begin
                ld_rdata_reg <= word_next;
            end

            if (if_req && !if_win) begin
                starve_cnt_reg <= starve_hit ? starve_cnt_reg : starve_cnt_reg + 1'b1;
            end else begin
                starve_cnt_reg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized plus directed bench for rom_arbiter: a reference model queues expected
// responses at grant time and a separate monitor compares them when they fall due.
module tb_rom_arbiter;

    localparam logic [31:0] BASE  = 32'hBFC00000;
    localparam int          SIZE  = 32'h1000;
    localparam int          LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, ld_req;
    logic [31:0] if_addr, ld_addr;
    logic        if_gnt, if_rvalid, if_err, ld_gnt, ld_rvalid, ld_err;
    logic [31:0] if_rdata, ld_rdata, rom_addr, rom_dout;

    logic [7:0]  mem [SIZE];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;

    typedef struct {
        bit          is_if;
        bit          err;
        logic [31:0] data;
        int          due;
    } resp_t;
    resp_t exp_q[$];

    rom_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt),
        .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
        .rom_addr(rom_addr), .rom_dout(rom_dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] rom_read(logic [31:0] a);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            logic [32:0] off;
            off = {1'b0, a} - {1'b0, BASE} + 33'(k);
            w[8*k +: 8] = (off < 33'(SIZE)) ? mem[off[11:0]] : 8'hEE;
        end
        return w;
    endfunction

    assign rom_dout = rom_read(rom_addr);

    function automatic bit is_fault(logic [31:0] a, bit fetch);
        longint unsigned x;
        x = longint'(a);
        return (x < longint'(BASE)) || (x + 3 > longint'(BASE) + SIZE - 1) || (fetch && (x % 4 != 0));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Reference model: arbitration by the stated rules, expectations queued at grant time.
    int          starve = 0;
    logic [31:0] last_addr = BASE;
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
            chk("rst_ld_gnt", {31'b0, ld_gnt}, 32'd0);
            starve    = 0;
            last_addr = BASE;
        end else begin
            bit          win_if, win_ld, f;
            logic [31:0] a;
            resp_t       e;
            win_if = if_req && (!ld_req || starve == LIMIT);
            win_ld = ld_req && !win_if;
            chk("if_gnt", {31'b0, if_gnt}, {31'b0, win_if});
            chk("ld_gnt", {31'b0, ld_gnt}, {31'b0, win_ld});
            if (win_if || win_ld) begin
                a         = win_if ? if_addr : ld_addr;
                f         = is_fault(a, win_if);
                e.is_if   = win_if;
                e.err     = f;
                e.data    = f ? 32'h0 : rom_read(a);
                e.due     = cyc + 1;
                exp_q.push_back(e);
                last_addr = a;
            end
            chk("rom_addr", rom_addr, last_addr);
            starve = (if_req && !win_if) ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        end
    end

    // Monitor: pops the response due this cycle and compares what the DUT presents.
    always @(negedge clk) begin
        if (!rst) begin
            while (exp_q.size() > 0 && exp_q[0].due <= cyc) void'(exp_q.pop_front());
            chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
            chk("rst_ld_rvalid", {31'b0, ld_rvalid}, 32'd0);
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            resp_t e;
            e = exp_q.pop_front();
            if (e.is_if) begin
                chk("ld_rvalid_idle", {31'b0, ld_rvalid}, 32'd0);
                if (if_flush) begin
                    chk("if_rvalid_flush", {31'b0, if_rvalid}, 32'd0);
                    chk("if_err_flush", {31'b0, if_err}, 32'd0);
                end else begin
                    chk("if_rvalid", {31'b0, if_rvalid}, 32'd1);
                    chk("if_err", {31'b0, if_err}, {31'b0, e.err});
                    chk("if_rdata", if_rdata, e.data);
                end
            end else begin
                chk("if_rvalid_idle", {31'b0, if_rvalid}, 32'd0);
                chk("ld_rvalid", {31'b0, ld_rvalid}, 32'd1);
                chk("ld_err", {31'b0, ld_err}, {31'b0, e.err});
                chk("ld_rdata", ld_rdata, e.data);
            end
        end else begin
            chk("if_rvalid_none", {31'b0, if_rvalid}, 32'd0);
            chk("ld_rvalid_none", {31'b0, ld_rvalid}, 32'd0);
        end
    end

    // Outputs sampled by the driver in the most recent cycle.
    logic        s_if_gnt, s_ld_gnt, s_if_rvalid, s_if_err, s_ld_rvalid, s_ld_err;
    logic [31:0] s_if_rdata, s_ld_rdata, s_rom_addr;

    task automatic drive();
        @(negedge clk);
        s_if_gnt = if_gnt;       s_ld_gnt = ld_gnt;
        s_if_rvalid = if_rvalid; s_if_err = if_err; s_if_rdata = if_rdata;
        s_ld_rvalid = ld_rvalid; s_ld_err = ld_err; s_ld_rdata = ld_rdata;
        s_rom_addr = rom_addr;
        @(posedge clk);
        #1;
        if (s_if_gnt) if_req = 1'b0;
        if (s_ld_gnt) ld_req = 1'b0;
        if_flush = 1'b0;
    endtask

    function automatic logic [31:0] gen_addr(bit fetch);
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 7) return fetch ? BASE + ($urandom_range(0, 32'h3FF) << 2) : BASE + $urandom_range(0, 32'hFFF);
        if (r == 7) return BASE + 32'hFFC + $urandom_range(0, 3);
        if (r == 8) return BASE - 32'd1 - $urandom_range(0, 7);
        return $urandom;
    endfunction

    logic [1:0] t2_exp [6];

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;
        t2_exp = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        rst = 1'b0; if_req = 1'b0; ld_req = 1'b0; if_flush = 1'b0;
        if_addr = '0; ld_addr = '0;
        repeat (3) drive();
        chk("reset_rom_addr", s_rom_addr, BASE);
        chk("reset_if_rdata", s_if_rdata, 32'h0);
        rst = 1'b1;
        drive();

        // Single fetch from the first ROM word.
        if_req = 1'b1; if_addr = BASE;
        drive();
        chk("t1_gnt", {31'b0, s_if_gnt}, 32'd1);
        drive();
        chk("t1_rvalid", {31'b0, s_if_rvalid}, 32'd1);
        chk("t1_rdata", s_if_rdata, 32'h00500013);
        chk("t1_err", {31'b0, s_if_err}, 32'd0);

        // Both requesting every cycle: IF wins only once it has lost STARVE_LIMIT times.
        for (int k = 0; k < 6; k++) begin
            if_req = 1'b1; if_addr = BASE + 32'h10;
            ld_req = 1'b1; ld_addr = BASE + 32'h21;
            drive();
            chk($sformatf("t2_order_%0d", k), {30'b0, s_if_gnt, s_ld_gnt}, {30'b0, t2_exp[k]});
        end
        if_req = 1'b0; ld_req = 1'b0;
        drive();

        // Alignment and range faults.
        if_req = 1'b1; if_addr = BASE + 32'h2;
        drive(); drive();
        chk("t3_if_err", {31'b0, s_if_err}, 32'd1);
        chk("t3_if_rdata", s_if_rdata, 32'h0);
        ld_req = 1'b1; ld_addr = BASE + 32'h2;
        drive(); drive();
        chk("t3_ld_err", {31'b0, s_ld_err}, 32'd0);
        chk("t3_ld_rdata", s_ld_rdata, {mem[5], mem[4], mem[3], mem[2]});
        ld_req = 1'b1; ld_addr = BASE + 32'hFFE;
        drive(); drive();
        chk("t3_ld_top_err", {31'b0, s_ld_err}, 32'd1);
        ld_req = 1'b1; ld_addr = 32'h0;
        drive(); drive();
        chk("t3_ld_zero_err", {31'b0, s_ld_err}, 32'd1);

        // Flush drops the returning fetch but not a fetch granted in the same cycle.
        if_req = 1'b1; if_addr = BASE + 32'h4;
        drive();
        if_req = 1'b1; if_addr = BASE + 32'h8; if_flush = 1'b1;
        drive();
        chk("t4_flush_rvalid", {31'b0, s_if_rvalid}, 32'd0);
        chk("t4_new_gnt", {31'b0, s_if_gnt}, 32'd1);
        drive();
        chk("t4_next_rvalid", {31'b0, s_if_rvalid}, 32'd1);
        chk("t4_next_rdata", s_if_rdata, {mem[11], mem[10], mem[9], mem[8]});

        // Reset right after a load grant discards its response.
        ld_req = 1'b1; ld_addr = BASE + 32'h40;
        drive();
        rst = 1'b0;
        drive();
        chk("t5_ld_rvalid", {31'b0, s_ld_rvalid}, 32'd0);
        drive();
        chk("t5_rom_addr", s_rom_addr, BASE);
        chk("t5_ld_rdata", s_ld_rdata, 32'h0);
        chk("t5_if_rdata", s_if_rdata, 32'h0);
        chk("t5_ld_err", {31'b0, s_ld_err}, 32'd0);
        rst = 1'b1;
        drive();
        chk("t5_post_rvalid", {31'b0, s_ld_rvalid}, 32'd0);

        // Random traffic with held requests and random flushes.
        for (int n = 0; n < 400; n++) begin
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req = 1'b1; if_addr = gen_addr(1'b1);
            end
            if (!ld_req && $urandom_range(0, 2) != 0) begin
                ld_req = 1'b1; ld_addr = gen_addr(1'b0);
            end
            if_flush = ($urandom_range(0, 4) == 0);
            drive();
        end
        if_req = 1'b0; ld_req = 1'b0;
        repeat (3) drive();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
